// File: rtl/mem_access.sv
// Memory-access stage between EX and WB: req/ack data-memory bus, store lane alignment, load extension.
// Optional macro MEM_MISALIGN_TRAP_EN turns misaligned H/HU/W accesses into bus-less misalign completions.
module mem_access #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        MemType,
    input  logic [31:0]       ALUOut_in,
    input  logic [31:0]       StoreData,
    input  logic [31:0]       pc4_in,
    input  logic [31:0]       COMPExOut_in,
    input  logic [1:0]        RWSel_in,
    input  logic              RegWe_in,
    input  logic [4:0]        Rd_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [31:0]       pc4,
    output logic [31:0]       COMPExOut,
    output logic [31:0]       ALUOut,
    output logic [31:0]       DRAMRd,
    output logic [1:0]        RWSel,
    output logic              RegWe,
    output logic [4:0]        Rd,
    output logic              misalign
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      r_state;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic        r_unsigned;
    logic        r_is_load;
    logic        r_regwe;

    logic        w_fire;
    logic        w_is_mem;
    logic [1:0]  w_size;
    logic [1:0]  w_lane;
    logic        w_regwe;
    logic        w_misalign;
    logic        w_trap;

    // Access size code: 0 = byte, 1 = half, 2 = word; undefined funct3 values fall into word.
    function automatic logic [1:0] size_of(input logic [2:0] mt);
        logic [1:0] s;
        if (mt[1])      s = 2'd2;
        else if (mt[0]) s = 2'd1;
        else            s = 2'd0;
        return s;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane,
                                           input logic is_store);
        logic [3:0] be;
        if (!is_store)        be = 4'b1111;
        else if (size == 2'd0) be = 4'b0001 << lane;
        else if (size == 2'd1) be = lane[1] ? 4'b1100 : 4'b0011;
        else                   be = 4'b1111;
        return be;
    endfunction

    function automatic logic [31:0] align_wdata(input logic [1:0] size, input logic [31:0] sd);
        logic [31:0] wd;
        if (size == 2'd0)      wd = {4{sd[7:0]}};
        else if (size == 2'd1) wd = {2{sd[15:0]}};
        else                   wd = sd;
        return wd;
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic uns,
                                                 input logic [1:0] lane, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = rd[8*lane +: 8];
        h = lane[1] ? rd[31:16] : rd[15:0];
        if (size == 2'd0)      res = uns ? {24'd0, b} : {{24{b[7]}}, b};
        else if (size == 2'd1) res = uns ? {16'd0, h} : {{16{h[15]}}, h};
        else                   res = rd;
        return res;
    endfunction

    assign ex_ready = (r_state == IDLE);
    assign w_fire   = ex_valid & ex_ready;
    assign w_is_mem = MemRead | MemWrite;
    assign w_size   = size_of(MemType);
    assign w_lane   = ALUOut_in[1:0];
    // Stores and writes to x0 never update the register file.
    assign w_regwe  = RegWe_in & (Rd_in != 5'd0) & ~MemWrite;

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = ((w_size == 2'd1) & w_lane[0]) | ((w_size == 2'd2) & (w_lane != 2'd0));
`else
    assign w_misalign = 1'b0;
`endif
    assign w_trap = w_is_mem & w_misalign;

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_misalign;
    assign misalign = r_misalign;
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_size     <= 2'd0;
            r_lane     <= 2'd0;
            r_unsigned <= 1'b0;
            r_is_load  <= 1'b0;
            r_regwe    <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= 4'd0;
            mem_wdata  <= 32'd0;
            wb_valid   <= 1'b0;
            pc4        <= 32'd0;
            COMPExOut  <= 32'd0;
            ALUOut     <= 32'd0;
            DRAMRd     <= 32'd0;
            RWSel      <= 2'd0;
            RegWe      <= 1'b0;
            Rd         <= 5'd0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
            RegWe    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        pc4       <= pc4_in;
                        COMPExOut <= COMPExOut_in;
                        ALUOut    <= ALUOut_in;
                        RWSel     <= RWSel_in;
                        Rd        <= Rd_in;
                        if (w_is_mem && !w_trap) begin
                            r_state    <= BUSY;
                            r_size     <= w_size;
                            r_lane     <= w_lane;
                            r_unsigned <= MemType[2] & ~MemType[1];
                            r_is_load  <= ~MemWrite;
                            r_regwe    <= w_regwe;
                            mem_req    <= 1'b1;
                            mem_we     <= MemWrite;
                            mem_addr   <= {ALUOut_in[ADDR_W-1:2], 2'b00};
                            mem_be     <= byte_en(w_size, w_lane, MemWrite);
                            mem_wdata  <= align_wdata(w_size, StoreData);
                        end else begin
                            wb_valid <= 1'b1;
                            DRAMRd   <= 32'd0;
                            RegWe    <= w_regwe & ~w_trap;
`ifdef MEM_MISALIGN_TRAP_EN
                            r_misalign <= w_trap;
`endif
                        end
                    end
                end
                BUSY: begin
                    // Bus signals stay frozen until the memory acknowledges.
                    if (mem_ack) begin
                        r_state  <= IDLE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        mem_be   <= 4'd0;
                        wb_valid <= 1'b1;
                        RegWe    <= r_regwe;
                        DRAMRd   <= r_is_load ? load_extract(r_size, r_unsigned, r_lane, mem_rdata)
                                              : 32'd0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage between EX and WB.
- Accepts one instruction per handshake from EX and runs loads/stores over a req/ack data-memory bus.
- Aligns store data and generates byte enables; extracts and sign- or zero-extends load data.
- Registers the WB operands pc4, COMPExOut, ALUOut, DRAMRd and RWSel, and holds EX off while a bus access is outstanding.

Parameters:
- ADDR_W, 32, data-memory byte-address width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- ex_valid  in  1  EX presents an instruction this cycle
- ex_ready  out  1  stage can accept; transfer occurs when ex_valid&ex_ready
- MemRead  in  1  instruction is a load
- MemWrite  in  1  instruction is a store
- MemType  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ALUOut_in  in  32  effective address / ALU result
- StoreData  in  32  rs2 value
- pc4_in  in  32  PC+4
- COMPExOut_in  in  32  comparator result
- RWSel_in  in  2  write-back select
- RegWe_in  in  1  register write enable
- Rd_in  in  5  destination register
- mem_req  out  1  bus request, registered
- mem_we  out  1  1 = store
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned store data
- mem_ack  in  1  bus completion, valid only while mem_req=1
- mem_rdata  in  32  read word, valid with mem_ack
- wb_valid  out  1  WB outputs valid this cycle (one-cycle pulse per instruction)
- pc4, COMPExOut, ALUOut, DRAMRd  out  32 each  WB operands
- RWSel  out  2  WB select
- RegWe  out  1  gated register write enable (0 when wb_valid=0)
- Rd  out  5  destination register
- misalign  out  1  see Optional Feature; tied 0 when the feature is compiled out

Behaviour:
- Reset (rst_n=0 at an edge):
  - FSM goes to IDLE.
  - mem_req, mem_we, mem_be, wb_valid, RegWe, misalign go to 0.
  - All 32-bit outputs, RWSel and Rd go to 0.
  - Reset mid-access abandons the access: mem_req=0 next cycle and no wb_valid is produced.
- FSM states: IDLE, BUSY.
- ex_ready = (state==IDLE).
- IDLE, transfer of a non-memory instruction:
  - Next edge: WB outputs take the inputs, DRAMRd=0, wb_valid=1.
  - Latency 1 cycle; back-to-back throughput 1 per cycle.
- IDLE, transfer with MemRead|MemWrite:
  - Go to BUSY and latch all side-band fields.
  - mem_req=1 and mem_addr={addr[31:2],2'b00}; mem_we=MemWrite.
  - wb_valid=0 at that edge.
- Store byte enables and data:
  - B: be=1<<addr[1:0], wdata={4{sd[7:0]}}.
  - H: be=addr[1]?1100:0011, wdata={2{sd[15:0]}}.
  - W: be=1111, wdata=sd.
- Loads: be=1111.
- BUSY: mem_req, mem_addr, mem_we, mem_be, mem_wdata are held stable until mem_ack.
- BUSY with mem_ack=1 at an edge:
  - mem_req goes to 0 and the FSM returns to IDLE.
  - wb_valid=1 with latched side-band.
  - Loads: DRAMRd = extracted lane from mem_rdata, sign-extended (B, H) or zero-extended (BU, HU); W is passed through.
  - Stores: DRAMRd=0.
- Minimum memory latency: 2 edges from transfer to wb_valid. There is no upper bound (waits for ack).
- ex_ready rises in the cycle after ack. No new transfer is taken in the ack cycle.
- RegWe = latched RegWe_in & wb_valid.
- Stores force RegWe=0.
- Rd=0 forces RegWe=0.
- MemRead&MemWrite both set: treated as a store.
- Undefined MemType (011, 11x): treated as W.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - An H/HU access with addr[0]=1, or a W access with addr[1:0]!=0, issues no bus request.
  - Next edge: wb_valid=1, misalign=1, RegWe=0, DRAMRd=0, ALUOut=faulting address.
  - FSM stays IDLE.
- Undefined:
  - No check is made and misalign is tied 0.
  - H uses addr[1] only (addr[0] ignored); W ignores addr[1:0].

Test Plan:
- Reset: hold rst_n=0 with ex_valid=1 and MemRead=1 -> mem_req=0, wb_valid=0, all outputs 0.
- ALU op: ALUOut_in=0x1234, RWSel_in=2, RegWe_in=1, Rd_in=5 -> next cycle wb_valid=1, ALUOut=0x1234, RegWe=1; three back-to-back ops -> three consecutive wb_valid pulses.
- LB at addr 0x103, mem_rdata=0x80FF_FF00, ack 3 cycles after req -> ex_ready=0 while BUSY, DRAMRd=0xFFFF_FF80; repeat as LBU -> DRAMRd=0x0000_0080.
- SH at 0x202, StoreData=0xABCD_1234 -> mem_addr=0x200, be=1100, wdata=0x1234_1234, mem_we=1; after ack RegWe=0.
- Assert rst_n=0 while BUSY -> mem_req=0 next cycle, no wb_valid; after release a new LW completes normally.
- MEM_MISALIGN_TRAP_EN defined: LW at 0x1002 -> no mem_req, next cycle wb_valid=1, misalign=1, RegWe=0, ALUOut=0x1002; macro undefined: same LW -> mem_addr=0x1000 access.
